// File: rtl/sn_pkg.sv
// Shared constants for the SN76489 register interface: byte field positions,
// channel/type encodings and reset values.
package sn_pkg;

    localparam int LATCH_BIT = 7;
    localparam int CH_MSB    = 6;
    localparam int CH_LSB    = 5;
    localparam int TYPE_BIT  = 4;

    localparam logic [1:0] CH_NOISE  = 2'd3;
    localparam logic       TYPE_TONE = 1'b0;
    localparam logic       TYPE_ATT  = 1'b1;

    localparam logic [3:0] ATT_RST    = 4'hF;
    localparam logic [9:0] TONE_RST   = 10'd0;
    localparam logic [2:0] NOISE_RST  = 3'd0;
    localparam logic [7:0] STEREO_RST = 8'hFF;

    typedef enum logic [0:0] {
        BUSY_IDLE   = 1'b0,
        BUSY_ACTIVE = 1'b1
    } busy_state_t;

    function automatic logic is_latch_byte(input logic [7:0] b);
        return b[LATCH_BIT];
    endfunction

endpackage

// File: rtl/sn_busy_timer.sv
// READY handshake timer: after a start, ready drops for exactly BUSY_CYCLES
// clocks, then returns high.
module sn_busy_timer
    import sn_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic ready
);

    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(BUSY_CYCLES - 1);

    busy_state_t   state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          ready_r, ready_nxt_s;

    // State, counter and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BUSY_IDLE;
            cnt_r   <= '0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    // Next-state: load on start, count down, leave when counter reaches zero
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            BUSY_IDLE: begin
                if (start) begin
                    state_nxt_s = BUSY_ACTIVE;
                    cnt_nxt_s   = LOAD_VAL;
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            BUSY_ACTIVE: begin
                if (cnt_r == '0) begin
                    state_nxt_s = BUSY_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = BUSY_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        ready_nxt_s = (state_nxt_s == BUSY_IDLE);
    end

    assign ready = ready_r;

endmodule

// File: rtl/sn_reg_ctrl.sv
// SN76489 host write decoder and register file (tone periods, attenuations,
// noise control). Optional Game Gear stereo register under SN_GG_STEREO_EN.
module sn_reg_ctrl
    import sn_pkg::*;
#(
    parameter int         BUSY_CYCLES = 32,
    parameter logic [3:0] ATT_RESET   = ATT_RST
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       wr_drop,
    output logic [9:0] tone_per0,
    output logic [9:0] tone_per1,
    output logic [9:0] tone_per2,
    output logic [3:0] att0,
    output logic [3:0] att1,
    output logic [3:0] att2,
    output logic [3:0] att3,
    output logic [2:0] noise_ctl,
    output logic       noise_rst
`ifdef SN_GG_STEREO_EN
    ,
    input  logic       stereo_we,
    output logic [7:0] stereo
`endif
);

    logic       ready_s, data_acc_s, start_s, drop_s, noise_pulse_s;
    logic [9:0] tone_r [3];
    logic [9:0] tone_nxt_s [3];
    logic [3:0] att_r [4];
    logic [3:0] att_nxt_s [4];
    logic [2:0] noise_r, noise_nxt_s;
    logic [1:0] latch_ch_r, latch_ch_nxt_s;
    logic       latch_type_r, latch_type_nxt_s;
    logic       wr_drop_r, noise_rst_r;
    logic [1:0] tgt_ch_s;
    logic       tgt_type_s;

`ifdef SN_GG_STEREO_EN
    logic       stereo_acc_s;
    logic [7:0] stereo_r;

    // A stereo write takes priority over a simultaneous data byte
    assign stereo_acc_s = stereo_we & ready_s;
    assign data_acc_s   = wr_en & ready_s & ~stereo_we;
    assign start_s      = data_acc_s | stereo_acc_s;

    // Game Gear stereo register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stereo_r <= STEREO_RST;
        end else if (stereo_acc_s) begin
            stereo_r <= wr_data;
        end else begin
            stereo_r <= stereo_r;
        end
    end

    assign stereo = stereo_r;
`else
    assign data_acc_s = wr_en & ready_s;
    assign start_s    = data_acc_s;
`endif

    assign drop_s = wr_en & ~data_acc_s;

    sn_busy_timer #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_busy (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_s),
        .ready(ready_s)
    );

    // A latch byte retargets immediately; a data byte uses the stored latch
    assign tgt_ch_s   = is_latch_byte(wr_data) ? wr_data[CH_MSB:CH_LSB] : latch_ch_r;
    assign tgt_type_s = is_latch_byte(wr_data) ? wr_data[TYPE_BIT] : latch_type_r;

    // Byte decode into next register-file contents
    always_comb begin
        tone_nxt_s       = tone_r;
        att_nxt_s        = att_r;
        noise_nxt_s      = noise_r;
        latch_ch_nxt_s   = latch_ch_r;
        latch_type_nxt_s = latch_type_r;
        noise_pulse_s    = 1'b0;
        if (data_acc_s) begin
            latch_ch_nxt_s   = tgt_ch_s;
            latch_type_nxt_s = tgt_type_s;
            if (tgt_type_s == TYPE_ATT) begin
                att_nxt_s[tgt_ch_s] = wr_data[3:0];
            end else if (tgt_ch_s == CH_NOISE) begin
                noise_nxt_s   = wr_data[2:0];
                noise_pulse_s = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (tgt_ch_s == 2'(i)) begin
                        if (is_latch_byte(wr_data)) begin
                            tone_nxt_s[i][3:0] = wr_data[3:0];
                        end else begin
                            tone_nxt_s[i][9:4] = wr_data[5:0];
                        end
                    end else begin
                        tone_nxt_s[i] = tone_r[i];
                    end
                end
            end
        end else begin
            noise_pulse_s = 1'b0;
        end
    end

    // Register file, latch and pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) tone_r[i] <= TONE_RST;
            for (int i = 0; i < 4; i++) att_r[i] <= ATT_RESET;
            noise_r      <= NOISE_RST;
            latch_ch_r   <= 2'd0;
            latch_type_r <= TYPE_TONE;
            wr_drop_r    <= 1'b0;
            noise_rst_r  <= 1'b0;
        end else begin
            tone_r       <= tone_nxt_s;
            att_r        <= att_nxt_s;
            noise_r      <= noise_nxt_s;
            latch_ch_r   <= latch_ch_nxt_s;
            latch_type_r <= latch_type_nxt_s;
            wr_drop_r    <= drop_s;
            noise_rst_r  <= noise_pulse_s;
        end
    end

    assign ready     = ready_s;
    assign wr_drop   = wr_drop_r;
    assign tone_per0 = tone_r[0];
    assign tone_per1 = tone_r[1];
    assign tone_per2 = tone_r[2];
    assign att0      = att_r[0];
    assign att1      = att_r[1];
    assign att2      = att_r[2];
    assign att3      = att_r[3];
    assign noise_ctl = noise_r;
    assign noise_rst = noise_rst_r;

endmodule

// File: tb/tb_sn_reg_ctrl.sv
// Directed self-checking bench for sn_reg_ctrl (stereo checks when
// SN_GG_STEREO_EN is defined).
module tb_sn_reg_ctrl;

    localparam int BC = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready, wr_drop, noise_rst;
    logic [9:0] tone_per0, tone_per1, tone_per2;
    logic [3:0] att0, att1, att2, att3;
    logic [2:0] noise_ctl;
`ifdef SN_GG_STEREO_EN
    logic       stereo_we;
    logic [7:0] stereo;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sn_reg_ctrl #(
        .BUSY_CYCLES(BC),
        .ATT_RESET  (4'hF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ready    (ready),
        .wr_drop  (wr_drop),
        .tone_per0(tone_per0),
        .tone_per1(tone_per1),
        .tone_per2(tone_per2),
        .att0     (att0),
        .att1     (att1),
        .att2     (att2),
        .att3     (att3),
        .noise_ctl(noise_ctl),
        .noise_rst(noise_rst)
`ifdef SN_GG_STEREO_EN
        ,
        .stereo_we(stereo_we),
        .stereo   (stereo)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with ready high or after a timeout
    task automatic wait_ready();
        for (int i = 0; i < 200 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) check("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    // Single accepted byte; returns at the negedge after the accept edge
    task automatic wr(input logic [7:0] d);
        wait_ready();
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
`ifdef SN_GG_STEREO_EN
        stereo_we = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_att0", {28'd0, att0}, 32'hF);
        check("rst_att1", {28'd0, att1}, 32'hF);
        check("rst_att2", {28'd0, att2}, 32'hF);
        check("rst_att3", {28'd0, att3}, 32'hF);
        check("rst_tone0", {22'd0, tone_per0}, 32'h0);
        check("rst_tone2", {22'd0, tone_per2}, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_noise_rst", {31'd0, noise_rst}, 32'd0);
        check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(8'h8E);
        check("tone0_low", {22'd0, tone_per0}, 32'h00E);
        check("ready_low_after_accept", {31'd0, ready}, 32'd0);
        wr(8'h0F);
        check("tone0_full", {22'd0, tone_per0}, 32'h0FE);
        check("tone1_unchanged", {22'd0, tone_per1}, 32'h000);
        check("att0_unchanged", {28'd0, att0}, 32'hF);

        wr(8'hD5);
        check("att2_latch", {28'd0, att2}, 32'h5);
        wr(8'h03);
        check("att2_data", {28'd0, att2}, 32'h3);
        check("tone0_kept", {22'd0, tone_per0}, 32'h0FE);

        wr(8'hA5);
        wr(8'h12);
        check("tone1_full", {22'd0, tone_per1}, 32'h125);

        wr(8'hE4);
        check("noise_ctl", {29'd0, noise_ctl}, 32'h4);
        check("noise_rst_hi", {31'd0, noise_rst}, 32'd1);
        @(negedge clk);
        check("noise_rst_lo", {31'd0, noise_rst}, 32'd0);

        // Accept at edge t, then attempt a write at every edge t+1..t+BC-1
        wait_ready();
        wr_en   = 1'b1;
        wr_data = 8'h81;
        for (int i = 1; i <= BC; i++) begin
            @(negedge clk);
            check($sformatf("busy_ready_%0d", i), {31'd0, ready}, 32'd0);
            check($sformatf("busy_drop_%0d", i), {31'd0, wr_drop}, (i == 1) ? 32'd0 : 32'd1);
            wr_data = 8'h9A;
            wr_en   = (i <= BC - 1);
        end
        @(negedge clk);
        check("ready_back", {31'd0, ready}, 32'd1);
        check("drop_clear", {31'd0, wr_drop}, 32'd0);
        check("tone0_after_busy", {22'd0, tone_per0}, 32'h0F1);
        check("att0_not_written", {28'd0, att0}, 32'hF);

        wr(8'h7F);
        check("data_bit6_ignored", {22'd0, tone_per0}, 32'h3F1);

        // Reset in the middle of a busy window
        wr(8'hB7);
        check("att1_set", {28'd0, att1}, 32'h7);
        repeat (3) @(negedge clk);
        check("mid_busy_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        check("async_rst_att1", {28'd0, att1}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_tone0", {22'd0, tone_per0}, 32'h0);

`ifdef SN_GG_STEREO_EN
        check("stereo_rst", {24'd0, stereo}, 32'hFF);
        stereo_we = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'hF0;
        @(negedge clk);
        stereo_we = 1'b0;
        wr_en     = 1'b0;
        check("stereo_val", {24'd0, stereo}, 32'hF0);
        check("stereo_drop", {31'd0, wr_drop}, 32'd1);
        check("stereo_no_data", {28'd0, att3}, 32'hF);
        for (int i = 1; i < BC; i++) @(negedge clk);
        check("stereo_busy_end", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("stereo_ready", {31'd0, ready}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
